pixel_scan_scheduler: RTL and testbench
=======================================

PIXEL_SCAN_SCHEDULER -- requirements
Module: pixel_scan_scheduler

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameter H_TOTAL, default 800, clocks per line including blanking.
REQ-003 SHALL have parameter H_SYNC_START, default 656, first hcount with hsync asserted.
REQ-004 SHALL have parameter H_SYNC_END, default 752, first hcount after hsync.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_TOTAL, default 525, lines per frame.
REQ-007 SHALL have parameter V_SYNC_START, default 490, first vcount with vsync asserted.
REQ-008 SHALL have parameter V_SYNC_END, default 492, first vcount after vsync.
REQ-009 SHALL have port clk, input, 1, single clock, rising edge.
REQ-010 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-011 SHALL have port pix_en, input, 1, pixel-rate enable; all state advances only when high.
REQ-012 SHALL have port note_hit, input, 1, note layer covers queried pixel; valid one enabled cycle after query.
REQ-013 SHALL have port staff_hit, input, 1, staff layer hit; same timing as note_hit.
REQ-014 SHALL have port text_hit, input, 1, text layer hit; same timing as note_hit.
REQ-015 SHALL have port instrument_sel, input, 2, requested instrument (00 violin, 01 piano, 10 electric, 11 default).
REQ-016 SHALL have port hcount, output, 10, query x coordinate to layer sources.
REQ-017 SHALL have port vcount, output, 10, query y coordinate to layer sources.
REQ-018 SHALL have port pixel_type, output, 2, to color block: 00 note, 01 staff, 10 text, 11 background.
REQ-019 SHALL have port instrument_type, output, 2, to color block.
REQ-020 SHALL have ports hsync, vsync, output, 1 each, active-low syncs aligned to pixel_type.
REQ-021 SHALL have port active, output, 1, high when pixel_type belongs to visible area.
REQ-022 SHALL have port frame_start, output, 1, one-enabled-cycle pulse aligned to pixel (0,0) output.

Function
REQ-023 SHALL increment hcount each enabled cycle; at H_TOTAL-1 wrap to 0 and increment vcount.
REQ-024 SHALL wrap vcount from V_TOTAL-1 to 0 in the same cycle hcount wraps.
REQ-025 SHALL hold all registers, including pipeline stages, when pix_en is low.
REQ-026 SHALL use a 2-stage pipeline: query at stage 0, hits sampled at stage 1, outputs registered at stage 2 (latency 2 enabled cycles from hcount/vcount to pixel_type).
REQ-027 SHALL delay visible-area, hsync, vsync and frame_start by the same 2 stages so all outputs describe one pixel.
REQ-028 SHALL resolve simultaneous hits by fixed priority note > text > staff > background.
REQ-029 SHALL force pixel_type 11 and active low when the delayed coordinate is outside H_ACTIVE x V_ACTIVE, ignoring hits.
REQ-030 SHALL assert hsync low for H_SYNC_START <= hcount < H_SYNC_END, vsync low for V_SYNC_START <= vcount < V_SYNC_END.
REQ-031 SHALL drive instrument_type from instrument_sel, delayed 2 stages, unless REQ-035 applies.

Reset
REQ-032 SHALL on rst_n low immediately set hcount=0, vcount=0, all pipeline stages cleared, pixel_type=11, instrument_type=11, hsync=1, vsync=1, active=0, frame_start=0.
REQ-033 SHALL after rst_n deassertion output first query (0,0) on the first enabled edge, frame_start pulsing two enabled cycles later.
REQ-034 SHALL abandon any partial frame on mid-frame reset; no stale pipeline data appears after release.

Configuration
REQ-035 SHALL, with INSTRUMENT_LATCH_EN defined, capture instrument_sel only at the enabled cycle issuing query (0,0), holding it for the whole frame (tear-free); without it, instrument_sel is tracked every pixel per REQ-031.

Verification
REQ-036 SHALL test: reset, pix_en=1 for 800 cycles -> hcount 0..799 then 0, vcount 0->1, frame_start one pulse at cycle 2.
REQ-037 SHALL test: note_hit=text_hit=staff_hit=1 at pixel (10,10), instrument_sel=01 -> pixel_type 00, instrument_type 01, active 1.
REQ-038 SHALL test: text_hit=staff_hit=1 -> 10; staff_hit only -> 01; no hits -> 11; any hit at (700,10) -> 11, active 0.
REQ-039 SHALL test: full frame -> hsync low exactly 96 clocks per line, vsync low lines 490-491, wrap 524->0.
REQ-040 SHALL test: pix_en toggled 1-0-1 mid-line -> outputs and counters frozen during low, no skipped pixel.
REQ-041 SHALL test: INSTRUMENT_LATCH_EN defined, instrument_sel 00->10 mid-frame -> instrument_type stays 00 until next frame_start, then 10.

Source files
------------

// File: rtl/pixel_scan_scheduler.sv
// Raster scan counter with a 2-stage layer-hit pipeline feeding the color block.
// Optional INSTRUMENT_LATCH_EN: instrument captured once per frame at query (0,0).
module pixel_scan_scheduler #(
  parameter int H_ACTIVE     = 640,
  parameter int H_TOTAL      = 800,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_END   = 752,
  parameter int V_ACTIVE     = 480,
  parameter int V_TOTAL      = 525,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 492
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pix_en,
  input  logic       note_hit,
  input  logic       staff_hit,
  input  logic       text_hit,
  input  logic [1:0] instrument_sel,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  output logic [1:0] pixel_type,
  output logic [1:0] instrument_type,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic       frame_start
);

  localparam logic [9:0] HA  = 10'(H_ACTIVE);
  localparam logic [9:0] HL  = 10'(H_TOTAL - 1);
  localparam logic [9:0] HSS = 10'(H_SYNC_START);
  localparam logic [9:0] HSE = 10'(H_SYNC_END);
  localparam logic [9:0] VA  = 10'(V_ACTIVE);
  localparam logic [9:0] VL  = 10'(V_TOTAL - 1);
  localparam logic [9:0] VSS = 10'(V_SYNC_START);
  localparam logic [9:0] VSE = 10'(V_SYNC_END);

  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;
  logic       s1_vis_q, s1_vis_d;
  logic       s1_hs_q, s1_hs_d;
  logic       s1_vs_q, s1_vs_d;
  logic       s1_fs_q, s1_fs_d;
  logic [1:0] s1_ins_q, s1_ins_d;
  logic [1:0] ptype_q, ptype_d;
  logic [1:0] ins_q, ins_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       act_q, act_d;
  logic       fs_q, fs_d;
  logic       fs0;
  logic [1:0] ins0;
  logic [1:0] hit_type;

`ifdef INSTRUMENT_LATCH_EN
  logic [1:0] ins_lat_q, ins_lat_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ins_lat_q <= 2'b11;
    else        ins_lat_q <= ins_lat_d;
  end

  // New selection only takes effect at the top of a frame.
  always_comb begin
    ins0      = fs0 ? instrument_sel : ins_lat_q;
    ins_lat_d = (pix_en && fs0) ? instrument_sel : ins_lat_q;
  end
`else
  always_comb ins0 = instrument_sel;
`endif

  assign fs0 = (hcount_q == 10'd0) && (vcount_q == 10'd0);

  always_comb begin
    if (note_hit)       hit_type = 2'b00;
    else if (text_hit)  hit_type = 2'b10;
    else if (staff_hit) hit_type = 2'b01;
    else                hit_type = 2'b11;
  end

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    s1_vis_d = s1_vis_q;
    s1_hs_d  = s1_hs_q;
    s1_vs_d  = s1_vs_q;
    s1_fs_d  = s1_fs_q;
    s1_ins_d = s1_ins_q;
    ptype_d  = ptype_q;
    ins_d    = ins_q;
    hs_d     = hs_q;
    vs_d     = vs_q;
    act_d    = act_q;
    fs_d     = fs_q;
    if (pix_en) begin
      if (hcount_q == HL) begin
        hcount_d = 10'd0;
        vcount_d = (vcount_q == VL) ? 10'd0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
      s1_vis_d = (hcount_q < HA) && (vcount_q < VA);
      s1_hs_d  = !((hcount_q >= HSS) && (hcount_q < HSE));
      s1_vs_d  = !((vcount_q >= VSS) && (vcount_q < VSE));
      s1_fs_d  = fs0;
      s1_ins_d = ins0;
      // Hits arriving now belong to the coordinate held in stage 1.
      ptype_d  = s1_vis_q ? hit_type : 2'b11;
      act_d    = s1_vis_q;
      hs_d     = s1_hs_q;
      vs_d     = s1_vs_q;
      fs_d     = s1_fs_q;
      ins_d    = s1_ins_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q <= 10'd0;
      vcount_q <= 10'd0;
      s1_vis_q <= 1'b0;
      s1_hs_q  <= 1'b1;
      s1_vs_q  <= 1'b1;
      s1_fs_q  <= 1'b0;
      s1_ins_q <= 2'b11;
      ptype_q  <= 2'b11;
      ins_q    <= 2'b11;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      act_q    <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
      s1_vis_q <= s1_vis_d;
      s1_hs_q  <= s1_hs_d;
      s1_vs_q  <= s1_vs_d;
      s1_fs_q  <= s1_fs_d;
      s1_ins_q <= s1_ins_d;
      ptype_q  <= ptype_d;
      ins_q    <= ins_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      act_q    <= act_d;
      fs_q     <= fs_d;
    end
  end

  assign hcount          = hcount_q;
  assign vcount          = vcount_q;
  assign pixel_type      = ptype_q;
  assign instrument_type = ins_q;
  assign hsync           = hs_q;
  assign vsync           = vs_q;
  assign active          = act_q;
  assign frame_start     = fs_q;

endmodule

// File: tb/tb_pixel_scan_scheduler.sv
// Directed bench: default-timing DUT for pixel vectors, short-frame DUT
// for whole-frame sync, wrap and instrument behaviour.
module tb_pixel_scan_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pix_en;
  logic       note_hit, staff_hit, text_hit;
  logic [1:0] instrument_sel;
  logic [9:0] hcount, vcount;
  logic [1:0] pixel_type, instrument_type;
  logic       hsync, vsync, active, frame_start;

  logic [9:0] s_hcount, s_vcount;
  logic [1:0] s_pixel_type, s_instrument_type;
  logic       s_hsync, s_vsync, s_active, s_frame_start;

  always #5 clk = ~clk;

  pixel_scan_scheduler u_dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .note_hit(note_hit), .staff_hit(staff_hit), .text_hit(text_hit),
    .instrument_sel(instrument_sel),
    .hcount(hcount), .vcount(vcount),
    .pixel_type(pixel_type), .instrument_type(instrument_type),
    .hsync(hsync), .vsync(vsync), .active(active),
    .frame_start(frame_start)
  );

  pixel_scan_scheduler #(
    .V_ACTIVE(12), .V_TOTAL(20), .V_SYNC_START(14), .V_SYNC_END(16)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
    .note_hit(1'b0), .staff_hit(1'b0), .text_hit(1'b0),
    .instrument_sel(instrument_sel),
    .hcount(s_hcount), .vcount(s_vcount),
    .pixel_type(s_pixel_type), .instrument_type(s_instrument_type),
    .hsync(s_hsync), .vsync(s_vsync), .active(s_active),
    .frame_start(s_frame_start)
  );

  typedef struct packed {
    logic [9:0] h;
    logic [9:0] v;
    logic       n;
    logic       s;
    logic       t;
    logic [1:0] sel;
    logic [1:0] ty;
    logic       act;
    logic       hs;
  } vec_t;

  localparam int NV = 8;
  vec_t vt[NV];

  int nerr = 0;
  int nchk = 0;
  logic       sel_mode;
  logic [1:0] sel_manual;
  logic [9:0] lq_h, lq_v;

  // Layer sources answer one enabled cycle after the query.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lq_h <= 10'd0;
      lq_v <= 10'd0;
    end else if (pix_en) begin
      lq_h <= hcount;
      lq_v <= vcount;
    end
  end

  always_comb begin
    note_hit  = 1'b0;
    staff_hit = 1'b0;
    text_hit  = 1'b0;
    instrument_sel = sel_mode ? sel_manual : 2'b00;
    for (int i = 0; i < NV; i++) begin
      if (!sel_mode && lq_h == vt[i].h && lq_v == vt[i].v) begin
        note_hit  = vt[i].n;
        staff_hit = vt[i].s;
        text_hit  = vt[i].t;
      end
      if (!sel_mode && hcount == vt[i].h && vcount == vt[i].v)
        instrument_sel = vt[i].sel;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_ins(input logic [1:0] s);
`ifdef INSTRUMENT_LATCH_EN
    return 2'b00;
`else
    return s;
`endif
  endfunction

  int en_edges;
  int hbad, fs_cnt, fs2, v799;
  int lin, frz_bad;
  logic [9:0] sv_h, sv_v;
  logic [1:0] sv_ty;
  logic       sv_act;
  int hs_low[20];
  int vs_low[20];
  int act_cnt, sfs_cnt, ins_bad, p, ln, hh, ei;
  bit latch_build;

  initial begin
`ifdef INSTRUMENT_LATCH_EN
    latch_build = 1'b1;
`else
    latch_build = 1'b0;
`endif
    //       h      v      n  s  t  sel    ty     act hs
    vt[0] = {10'd10,  10'd10, 1'b1, 1'b1, 1'b1, 2'b01, 2'b00, 1'b1, 1'b1};
    vt[1] = {10'd11,  10'd10, 1'b0, 1'b1, 1'b1, 2'b10, 2'b10, 1'b1, 1'b1};
    vt[2] = {10'd12,  10'd10, 1'b0, 1'b1, 1'b0, 2'b11, 2'b01, 1'b1, 1'b1};
    vt[3] = {10'd13,  10'd10, 1'b0, 1'b0, 1'b0, 2'b00, 2'b11, 1'b1, 1'b1};
    vt[4] = {10'd14,  10'd10, 1'b1, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b1};
    vt[5] = {10'd639, 10'd10, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1, 1'b1};
    vt[6] = {10'd640, 10'd10, 1'b1, 1'b0, 1'b0, 2'b10, 2'b11, 1'b0, 1'b1};
    vt[7] = {10'd700, 10'd10, 1'b1, 1'b1, 1'b1, 2'b00, 2'b11, 1'b0, 1'b0};

    sel_mode = 1'b0;
    sel_manual = 2'b00;
    rst_n = 1'b0;
    pix_en = 1'b0;
    #12;
    check("rst_hcount", hcount, 0);
    check("rst_vcount", vcount, 0);
    check("rst_pixel_type", pixel_type, 3);
    check("rst_instrument", instrument_type, 3);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_active", active, 0);
    check("rst_frame_start", frame_start, 0);

    @(negedge clk);
    rst_n = 1'b1;
    pix_en = 1'b1;
    hbad = 0; fs_cnt = 0; fs2 = 0; v799 = -1;
    for (int n = 1; n <= 800; n++) begin
      tick();
      if (hcount != 10'(n % 800)) hbad++;
      fs_cnt += int'(frame_start);
      if (n == 2) fs2 = int'(frame_start);
      if (n == 799) v799 = int'(vcount);
    end
    en_edges = 800;
    check("line_hcount_seq", hbad, 0);
    check("line_fs_pulses", fs_cnt, 1);
    check("line_fs_at_2", fs2, 1);
    check("line_vcount_799", v799, 0);
    check("line_wrap_vcount", vcount, 1);
    check("line_wrap_hcount", hcount, 0);

    for (int k = 0; k < NV; k++) begin
      lin = int'(vt[k].v) * 800 + int'(vt[k].h);
      while (en_edges < lin + 2) begin
        tick();
        en_edges++;
      end
      check($sformatf("vec%0d_type", k), pixel_type, vt[k].ty);
      check($sformatf("vec%0d_instr", k), instrument_type,
            exp_ins(vt[k].sel));
      check($sformatf("vec%0d_active", k), active, vt[k].act);
      check($sformatf("vec%0d_hsync", k), hsync, vt[k].hs);
      check($sformatf("vec%0d_vsync", k), vsync, 1);
      if (k == 1) begin
        sv_h = hcount; sv_v = vcount;
        sv_ty = pixel_type; sv_act = active;
        pix_en = 1'b0;
        frz_bad = 0;
        for (int i = 0; i < 4; i++) begin
          tick();
          if (hcount != sv_h || vcount != sv_v || pixel_type != sv_ty ||
              active != sv_act)
            frz_bad++;
        end
        check("freeze_hold", frz_bad, 0);
        pix_en = 1'b1;
        tick();
        en_edges++;
        check("freeze_resume_h", hcount, int'(sv_h) + 1);
      end
    end

    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_hcount", hcount, 0);
    check("midrst_vcount", vcount, 0);
    check("midrst_type", pixel_type, 3);
    check("midrst_hsync", hsync, 1);
    check("midrst_active", active, 0);
    sel_mode = 1'b1;
    sel_manual = 2'b00;
    act_cnt = 0; sfs_cnt = 0; ins_bad = 0;
    for (int l = 0; l < 20; l++) begin
      hs_low[l] = 0;
      vs_low[l] = 0;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 1; n <= 16002; n++) begin
      tick();
      if (n == 1) begin
        check("post_rst_type", pixel_type, 3);
        check("post_rst_active", active, 0);
      end
      if (n == 2) check("post_rst_fs", frame_start, 1);
      if (n == 8000) sel_manual = 2'b10;
      if (n >= 2 && n <= 16001) begin
        p = n - 2;
        ln = p / 800;
        hh = p % 800;
        if (!s_hsync) hs_low[ln]++;
        if (!s_vsync) vs_low[ln]++;
        act_cnt += int'(s_active);
        sfs_cnt += int'(s_frame_start);
        ei = (n >= 8002 && !latch_build) ? 2 : 0;
        if (int'(s_instrument_type) != ei) ins_bad++;
      end
      if (n == 15999) begin
        check("wrap_pre_v", s_vcount, 19);
        check("wrap_pre_h", s_hcount, 799);
      end
      if (n == 16000) begin
        check("wrap_post_v", s_vcount, 0);
        check("wrap_post_h", s_hcount, 0);
      end
      if (n == 16002) begin
        check("frame2_fs", s_frame_start, 1);
        check("frame2_instr", s_instrument_type, 2);
      end
    end
    for (int l = 0; l < 20; l++) begin
      check($sformatf("hsync_low_line%0d", l), hs_low[l], 96);
      check($sformatf("vsync_low_line%0d", l), vs_low[l],
            (l == 14 || l == 15) ? 800 : 0);
    end
    check("frame_active_cnt", act_cnt, 640 * 12);
    check("frame_fs_cnt", sfs_cnt, 1);
    check("frame_instr_bad", ins_bad, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
